// File: rtl/mfc_seq_tracker.sv
// Streaming statistics over signed 16-bit samples: running signed max with first index,
// equal / additive-inverse pair counts and MS differing-bit of the latest pair.
module mfc_seq_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             done,
  output logic             busy,
  output logic [15:0]      max_val,
  output logic [CNT_W-1:0] max_idx,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] ae_cnt,
  output logic [3:0]       last_d
);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_q, state_d;

  logic [15:0]      max_val_q, max_val_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] ae_cnt_q, ae_cnt_d;
  logic [3:0]       last_d_q, last_d_d;
  logic [15:0]      prev_q, prev_d;

  logic        beat;
  logic        gt_max;
  logic        eq_prev;
  logic        neg_prev;
  logic [15:0] diff;
  logic [3:0]  msb_diff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FIRST;
      S_FIRST: if (beat) state_d = in_last ? S_DONE : S_RUN;
      S_RUN:   if (beat && in_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == S_FIRST) || (state_q == S_RUN);
    in_ready = busy;
    done     = (state_q == S_DONE);
  end

  assign beat     = in_valid & in_ready;
  assign gt_max   = $signed(in_data) > $signed(max_val_q);
  assign eq_prev  = (in_data == prev_q);
  assign neg_prev = (in_data == (~prev_q + 16'd1));
  assign diff     = in_data ^ prev_q;

  // Highest set bit of the XOR wins; zero when the pair is identical.
  always_comb begin
    msb_diff = '0;
    for (int i = 0; i < 16; i++) begin
      if (diff[i]) msb_diff = 4'(i);
    end
  end

  always_comb begin
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    count_d   = count_q;
    eq_cnt_d  = eq_cnt_q;
    ae_cnt_d  = ae_cnt_q;
    last_d_d  = last_d_q;
    prev_d    = prev_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          max_val_d = '0;
          max_idx_d = '0;
          count_d   = '0;
          eq_cnt_d  = '0;
          ae_cnt_d  = '0;
          last_d_d  = '0;
          prev_d    = '0;
        end
      end
      S_FIRST: begin
        if (beat) begin
          max_val_d = in_data;
          max_idx_d = '0;
          count_d   = CNT_W'(1);
          prev_d    = in_data;
        end
      end
      S_RUN: begin
        if (beat) begin
          // count_q is already saturated, so the index saturates with it.
          if (gt_max) begin
            max_val_d = in_data;
            max_idx_d = count_q;
          end
          if (eq_prev) eq_cnt_d = sat_inc(eq_cnt_q);
          if (eq_prev || neg_prev) ae_cnt_d = sat_inc(ae_cnt_q);
          last_d_d = msb_diff;
          count_d  = sat_inc(count_q);
          prev_d   = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_val_q <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
      eq_cnt_q  <= '0;
      ae_cnt_q  <= '0;
      last_d_q  <= '0;
      prev_q    <= '0;
    end else begin
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      count_q   <= count_d;
      eq_cnt_q  <= eq_cnt_d;
      ae_cnt_q  <= ae_cnt_d;
      last_d_q  <= last_d_d;
      prev_q    <= prev_d;
    end
  end

  assign max_val = max_val_q;
  assign max_idx = max_idx_q;
  assign count   = count_q;
  assign eq_cnt  = eq_cnt_q;
  assign ae_cnt  = ae_cnt_q;
  assign last_d  = last_d_q;

endmodule

// File: tb/tb_mfc_seq_tracker.sv
// Scoreboarded bench for mfc_seq_tracker (CNT_W=4): expected final results are queued at the
// last beat and compared by a monitor whenever done pulses.
module tb_mfc_seq_tracker;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_last;
  logic             in_ready;
  logic             done;
  logic             busy;
  logic [15:0]      max_val;
  logic [CNT_W-1:0] max_idx;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] ae_cnt;
  logic [3:0]       last_d;

  mfc_seq_tracker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .done(done), .busy(busy), .max_val(max_val),
    .max_idx(max_idx), .count(count), .eq_cnt(eq_cnt), .ae_cnt(ae_cnt), .last_d(last_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mv, mi, cnt, eqc, aec, ld;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] cur_seq[$];
  int          checks = 0;
  int          failures = 0;
  int          seq_no = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Reference: results computed directly over the whole sample list.
  task automatic model_push();
    exp_t        e;
    int          n = cur_seq.size();
    int          best = 0;
    int          eqn = 0;
    int          aen = 0;
    logic [15:0] a, p, neg, x;
    e.ld = 0;
    for (int i = 1; i < n; i++) begin
      a = cur_seq[i];
      p = cur_seq[i-1];
      neg = 16'd0 - p;
      if ($signed(a) > $signed(cur_seq[best])) best = i;
      if (a == p) eqn++;
      if (a == p || a == neg) aen++;
      if (i == n - 1) begin
        x = a ^ p;
        for (int b = 0; b < 16; b++) if (x[b]) e.ld = b;
      end
    end
    e.mv  = int'(cur_seq[best]);
    e.mi  = sat(best);
    e.cnt = sat(n);
    e.eqc = sat(eqn);
    e.aec = sat(aen);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("max_val", int'(max_val), e.mv);
        check("max_idx", int'(max_idx), e.mi);
        check("count",   int'(count),   e.cnt);
        check("eq_cnt",  int'(eq_cnt),  e.eqc);
        check("ae_cnt",  int'(ae_cnt),  e.aec);
        check("last_d",  int'(last_d),  e.ld);
        $display("seq %0d: max=%h idx=%0d cnt=%0d eq=%0d ae=%0d d=%0d",
                 seq_no, max_val, max_idx, count, eq_cnt, ae_cnt, last_d);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_max_val"}, int'(max_val), 0);
    check({tag, "_max_idx"}, int'(max_idx), 0);
    check({tag, "_count"},   int'(count),   0);
    check({tag, "_eq_cnt"},  int'(eq_cnt),  0);
    check({tag, "_ae_cnt"},  int'(ae_cnt),  0);
    check({tag, "_last_d"},  int'(last_d),  0);
    check({tag, "_ready"},   int'(in_ready), 0);
    check({tag, "_busy"},    int'(busy),    0);
    check({tag, "_done"},    int'(done),    0);
  endtask

  task automatic run_seq(input int gmin, input int gmax, input bit noise);
    int n = cur_seq.size();
    seq_no++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("ready_after_start", int'(in_ready), 1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gmax, gmin)) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
      if (i == n - 1) model_push();
      in_valid = 1'b1;
      in_data  = cur_seq[i];
      in_last  = (i == n - 1);
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    check("done_pulse", int'(done), 1);
    @(negedge clk);
    check("done_clear", int'(done), 0);
    check("idle_ready", int'(in_ready), 0);
  endtask

  function automatic logic [15:0] rand_sample(input logic [15:0] p);
    case ($urandom_range(0, 6))
      0: return p;
      1: return 16'd0 - p;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset");

    in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid_count", int'(count), 0);
    check("idle_valid_ready", int'(in_ready), 0);
    in_valid = 1'b0; in_last = 1'b0;

    cur_seq = '{16'h0005, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h7FFF};
    run_seq(0, 0, 1'b0);
    cur_seq = '{16'h0003, 16'hFFFD, 16'hFFFD, 16'h0003, 16'h0001};
    run_seq(0, 1, 1'b1);
    cur_seq = '{16'h8000};
    run_seq(3, 3, 1'b0);
    cur_seq.delete();
    repeat (20) cur_seq.push_back(16'h0000);
    run_seq(0, 0, 1'b0);
    check("hold_count", int'(count), SAT);

    // Mid-run abort: partial results must vanish and not reach the scoreboard.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'(100 + i); in_last = 1'b0;
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    check("abort_count_before", int'(count), 3);
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check_zero("abort");
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;

    for (int s = 0; s < 25; s++) begin
      int n = $urandom_range(1, 20);
      logic [15:0] v;
      cur_seq.delete();
      v = 16'($urandom);
      for (int i = 0; i < n; i++) begin
        v = (i == 0) ? v : rand_sample(v);
        cur_seq.push_back(v);
      end
      run_seq(0, (s % 3 == 0) ? 0 : 2, 1'b1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
